// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the delay-timer controller.
//   timer_state_t   : controller state encoding
//   DELAY_W         : width of the downstream shift/count register
//   DEFAULT_PATTERN : start pattern searched for in the serial stream (MSB first)
package timer_pkg;

    typedef enum logic [1:0] {
        SRCH  = 2'd0,
        SHIFT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam int         DELAY_W         = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running 0..PERIOD-1 counter that paces count steps.
//   clk, reset : clock, synchronous active-high reset
//   clear      : forces the count to 0 (takes priority over enable)
//   enable     : advance the count this cycle, wrapping after PERIOD-1
//   wrap       : high while count == PERIOD-1
//   count      : current prescaler value, width $clog2(PERIOD)
module timer_prescaler #(
    parameter int PERIOD = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    output logic                      wrap,
    output logic [$clog2(PERIOD)-1:0] count
);

    localparam int W = $clog2(PERIOD);

    assign wrap = (count == W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: control FSM for the delay timer. Finds PATTERN in the serial
// data stream, strobes shift_ena for SHIFT_LEN cycles to load the delay into
// the downstream shift/count register, then issues one count_ena every PERIOD
// cycles until the register reads 0, and finally holds done until ack.
//   clk, reset : clock, synchronous active-high reset
//   abort      : (only with TIMER_CTRL_ABORT_EN) cancel SHIFT/COUNT, back to SRCH
//   data       : serial stream (also feeds the shift/count register)
//   q_in       : current value of the shift/count register
//   ack        : acknowledge of done
//   shift_ena  : load strobe to the register
//   count_ena  : single-cycle decrement strobe to the register
//   counting   : high while in COUNT
//   done       : high while in DONE
// Build option: define TIMER_CTRL_ABORT_EN to add the abort input.
//
// state | meaning
// SRCH  | shifting data into the history, looking for PATTERN
// SHIFT | shift_ena high, loading SHIFT_LEN bits into the register
// COUNT | prescaler running, decrementing the register each period
// DONE  | delay expired, done held until ack
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int         PERIOD    = 1000,
    parameter logic [3:0] PATTERN   = DEFAULT_PATTERN,
    parameter int         SHIFT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef TIMER_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               data,
    input  logic [DELAY_W-1:0] q_in,
    input  logic               ack,
    output logic               shift_ena,
    output logic               count_ena,
    output logic               counting,
    output logic               done
);

    localparam int PRESC_W = $clog2(PERIOD);
    localparam int SH_W    = $clog2(SHIFT_LEN + 1);

    timer_state_t        state;
    timer_state_t        next_state;
    // The three oldest bits are stored; together with the live data bit they
    // form the 4-bit history window, so a match on the bit sampled at an edge
    // moves the FSM at that same edge.
    logic [2:0]          hist;
    logic [3:0]          window;
    logic                match;
    logic [SH_W-1:0]     sh_cnt;
    logic                sh_last;
    logic                presc_clear;
    logic                presc_en;
    logic                presc_wrap;
    logic [PRESC_W-1:0]  presc_cnt;
    logic                period_end;
    logic                abort_hit;

`ifdef TIMER_CTRL_ABORT_EN
    assign abort_hit = abort && ((state == SHIFT) || (state == COUNT));
`else
    assign abort_hit = 1'b0;
`endif

    assign window     = {hist, data};
    assign match      = (state == SRCH) && (window == PATTERN);
    assign sh_last    = (sh_cnt == SH_W'(SHIFT_LEN - 1));
    assign period_end = presc_wrap && (presc_cnt == PRESC_W'(PERIOD - 1));

    // Held at 0 outside COUNT so COUNT always starts a fresh period.
    assign presc_clear = (state != COUNT) || abort_hit;
    assign presc_en    = (state == COUNT);

    timer_prescaler #(
        .PERIOD (PERIOD)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_en),
        .wrap   (presc_wrap),
        .count  (presc_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SRCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SRCH: begin
                if (match) next_state = SHIFT;
            end
            SHIFT: begin
                if (abort_hit)    next_state = SRCH;
                else if (sh_last) next_state = COUNT;
            end
            COUNT: begin
                if (abort_hit)                         next_state = SRCH;
                else if (period_end && (q_in == '0))   next_state = DONE;
            end
            DONE: begin
                if (ack) next_state = SRCH;
            end
            default: next_state = SRCH;
        endcase
    end

    always_comb begin
        shift_ena = (state == SHIFT);
        counting  = (state == COUNT);
        done      = (state == DONE);
        count_ena = (state == COUNT) && period_end && (q_in != '0) && !abort_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist   <= '0;
            sh_cnt <= '0;
        end else begin
            if (abort_hit || ((state == DONE) && ack)) begin
                hist <= '0;
            end else if (state == SRCH) begin
                hist <= window[2:0];
            end

            if ((state == SHIFT) && !sh_last && !abort_hit) begin
                sh_cnt <= sh_cnt + 1'b1;
            end else begin
                sh_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

    typedef struct {
        logic       rst;
        logic       d;
        logic       a;
        logic       ab;
        logic       chk;
        logic [3:0] exp;
        logic       chk_q;
        logic [3:0] exp_q;
    } vec_t;

    // {shift_ena, count_ena, counting, done}
    localparam logic [3:0] IDL = 4'b0000;
    localparam logic [3:0] SH  = 4'b1000;
    localparam logic [3:0] CE  = 4'b0110;
    localparam logic [3:0] CN  = 4'b0010;
    localparam logic [3:0] DN  = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] q_reg = 4'd0;
    logic [3:0] q_in;
    logic       shift_ena, count_ena, counting, done;
`ifdef TIMER_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // Model of the downstream shift/count register.
    always @(posedge clk) begin
        if (shift_ena)      q_reg <= {q_reg[2:0], data};
        else if (count_ena) q_reg <= q_reg - 4'd1;
    end
    assign q_in = q_reg;

    timer_ctrl #(.PERIOD(4)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef TIMER_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .data      (data),
        .q_in      (q_in),
        .ack       (ack),
        .shift_ena (shift_ena),
        .count_ena (count_ena),
        .counting  (counting),
        .done      (done)
    );

    function automatic void add(logic r, logic d, logic a, logic ab, logic c, logic [3:0] e);
        vec_t v;
        v.rst = r; v.d = d; v.a = a; v.ab = ab; v.chk = c; v.exp = e;
        v.chk_q = 1'b0; v.exp_q = 4'd0;
        vecs.push_back(v);
    endfunction

    function automatic void add_q(logic [3:0] q);
        int n;
        n = vecs.size() - 1;
        vecs[n].chk_q = 1'b1;
        vecs[n].exp_q = q;
    endfunction

    function automatic void add_bits(logic [7:0] bits, int len, logic [3:0] e);
        for (int i = len - 1; i >= 0; i--) add(1'b0, bits[i], 1'b0, 1'b0, 1'b1, e);
    endfunction

    initial begin
        logic [3:0] got;

        // Reset, then 0,0,1,1,0,1 and load 0,1,0,1.
        add(1, 0, 0, 0, 0, IDL);
        add_bits(8'b001101, 6, IDL);
        add_bits(8'b0101, 4, SH);
        // First COUNT cycle with 5 loaded; reset asserted here.
        add(1, 0, 0, 0, 1, CN); add_q(4'd5);
        // A full pattern is required after reset.
        add_bits(8'b101101, 6, IDL);
        add_bits(8'b0010, 4, SH);
        // Delay 2: 12 COUNT cycles, count_ena at 4th and 8th; ack in COUNT ignored.
        add(0, 0, 0, 0, 1, CN); add_q(4'd2);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 1, 0, 1, CN);
        add(0, 0, 0, 0, 1, CE);
        add(0, 0, 0, 0, 1, CN); add_q(4'd1);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 0, 0, 1, CE);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, CN);
        add_q(4'd0);
        add(0, 0, 0, 0, 1, DN);
        add(0, 0, 0, 0, 1, DN);
        add(0, 0, 1, 0, 1, DN);
        // Re-entry: earliest match after 4 SRCH samples; delay 0.
        add_bits(8'b1101, 4, IDL);
        add_bits(8'b0000, 4, SH);
        add(0, 0, 0, 0, 1, CN); add_q(4'd0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, CN);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 1, DN);
        add(0, 0, 1, 0, 1, DN);
        // 1,1,1,0,1 -> single detection; ack during COUNT ignored.
        add_bits(8'b11101, 5, IDL);
        add_bits(8'b0000, 4, SH);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 1, 0, 1, CN);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 1, 0, 1, DN);
        // 1,0,1,1,0,1 -> single detection on the final 1.
        add_bits(8'b101101, 6, IDL);
        add_bits(8'b0000, 4, SH);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, CN);
        add(0, 0, 1, 0, 1, DN);
`ifdef TIMER_CTRL_ABORT_EN
        // Abort in the 2nd SHIFT cycle.
        add_bits(8'b1101, 4, IDL);
        add(0, 0, 0, 0, 1, SH);
        add(0, 0, 0, 1, 1, SH);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, IDL);
        // Abort in the presc==PERIOD-1 cycle with q_in=1.
        add_bits(8'b1101, 4, IDL);
        add_bits(8'b0001, 4, SH);
        add(0, 0, 0, 0, 1, CN); add_q(4'd1);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 0, 0, 1, CN);
        add(0, 0, 0, 1, 1, CN);
        add(0, 0, 0, 0, 1, IDL); add_q(4'd1);
`endif
        add(0, 0, 0, 0, 1, IDL);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            data  = vecs[i].d;
            ack   = vecs[i].a;
`ifdef TIMER_CTRL_ABORT_EN
            abort = vecs[i].ab;
`endif
            #1;
            if (vecs[i].chk) begin
                checks++;
                got = {shift_ena, count_ena, counting, done};
                if (got !== vecs[i].exp) begin
                    errors++;
                    $display("FAIL vec%0d outputs {shift,count_ena,counting,done} got=%b exp=%b",
                             i, got, vecs[i].exp);
                end
            end
            if (vecs[i].chk_q) begin
                checks++;
                if (q_in !== vecs[i].exp_q) begin
                    errors++;
                    $display("FAIL vec%0d register q got=%0d exp=%0d", i, q_in, vecs[i].exp_q);
                end
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
